redtree_sched: RTL and testbench
================================

# redtree_sched

Sequencing controller for the FAN reduction tree. It accepts one beat of N operand/vec-id pairs per handshake and registers it. It identifies the maximal same-id subtrees (the partial-sum results) and drains them one per cycle, tagged with their vec id, to the downstream per-vector accumulator. It sits between the multiplier array output and that accumulator, and it owns the tree instance.

## Interface
- N, 4, operand count per beat; power of two, ≥ 2
- W, 8, operand width
- V, 3, vec-id width
- S, W+$clog2(N), sum width
- clk  in  1  clock; single clock domain
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  beat offered
- in_ready  out  1  beat accepted when in_valid && in_ready
- in_operands  in  N×W  unsigned operands, lane 0 = index 0
- in_vec_ids  in  N×V  vec id per lane
- out_valid  out  1  result available
- out_ready  in  1  downstream accepts
- out_sum  out  S  partial sum, zero-extended, no overflow possible
- out_vec_id  out  V  id of out_sum
- out_last  out  1  final result of the current beat
- busy  out  1  state != IDLE

## Operation
- States:
  - IDLE: in_ready=1. On an input handshake, capture the operands and ids, load the pending mask, and go to DRAIN.
  - DRAIN: out_valid=1 while the pending mask is nonzero.
- Candidates: N leaves plus N−1 tree nodes. Node (level l, pair i) covers leaves [i·2^(l+1), (i+1)·2^(l+1)−1].
- A candidate is a result if all its covered leaves share one id, and either it is the root or its parent's covered leaves are not uniform.
  - A lone leaf is a result when its sibling's id differs.
  - Results partition the leaf set, so a beat produces 1..N results.
- Non-aligned same-id runs yield several results with the same id (e.g. leaf 1 plus node(2,3)). Merging these is downstream's job.
- Drain order: ascending index of the lowest covered leaf. A priority encoder over the pending mask selects the next result. The selected bit clears on each out_valid && out_ready.
- out_last=1 when exactly one pending bit remains.
- On a handshake with out_last=1:
  - If in_valid, capture the new beat in the same cycle and stay in DRAIN.
  - Otherwise go to IDLE.
- in_ready = (state==IDLE) || (out_valid && out_ready && out_last), gated to 0 while rst.
- Arithmetic: sums are unsigned and S-bit. The N·(2^W−1) maximum fits, so there is no wrap.

## Timing
- Reset: state=IDLE, pending=0, capture regs=0. out_valid=0, out_last=0, busy=0, out_sum=0, out_vec_id=0. in_ready=0 during rst and 1 on the first cycle after.
- Latency: beat accepted at edge t gives the first result valid in cycle t+1. out_sum/out_vec_id come combinationally from the capture registers through the tree and mux, with no added register.
- Throughput: one result per cycle. Back-to-back beats have no bubble, because the next beat's first result is valid the cycle after the previous out_last handshake.
- Backpressure: while out_valid && !out_ready, out_sum, out_vec_id and out_last hold stable, and in_ready=0.
- Reset mid-DRAIN: remaining results are discarded. There is no output on the next cycle.

## Structure
- Shared package redtree_pkg holds:
  - state enum (IDLE, DRAIN)
  - candidate-count constant 2N−1
  - function mapping (level, pair) to a flat node index, offset N−(N>>l)+i
- Sub-module fan_sum_tree: combinational power-of-two adder tree exposing every node sum at the flat index above.
- The uniform-id detection, result mask, priority encoder and FSM live in redtree_sched.

## Test plan
Configuration for all cases: N=4, W=8, V=3, S=10.
- ids {2,2,2,2}, ops {1,2,3,4} → one result: sum 10, id 2, last=1.
- ids {0,1,2,3}, ops {5,6,7,8} → 5/0, 6/1, 7/2, 8/3 on consecutive cycles; last only on the 4th.
- ids {1,1,3,3}, ops {255,255,255,255} → 510/1 then 510/3, no overflow. ids all 7, ops all 255 → 1020/7.
- ids {0,1,1,1}, ops {1,2,3,4} → 1/0, 2/1, 7/1.
- Backpressure and back-to-back: run case 2 with out_ready low for 3 cycles at its 2nd result. Outputs hold 6/1, in_ready=0. Then present case 1 during the last handshake: it is accepted that cycle, and 10/2 appears the next cycle.
- Assert rst during case 2 after its 1st result → out_valid=0 and busy=0 the next cycle, in_ready=1 the cycle after release; no stale results.

Source files
------------

// File: rtl/redtree_pkg.sv
// Shared types and index helpers for the FAN reduction-tree scheduler.
package redtree_pkg;

  typedef enum logic {IDLE = 1'b0, DRAIN = 1'b1} state_t;

  localparam int N_DEFAULT        = 4;
  localparam int NUM_CAND_DEFAULT = 2 * N_DEFAULT - 1;

  function automatic int num_cand(input int n);
    return 2 * n - 1;
  endfunction

  // Flat position of tree node (level l, pair i) among the n-1 internal nodes.
  function automatic int node_idx(input int n, input int l, input int i);
    return n - (n >> l) + i;
  endfunction

endpackage

// File: rtl/fan_sum_tree.sv
// Combinational power-of-two adder tree; every internal node sum is exposed
// at its flat node index.
module fan_sum_tree
  import redtree_pkg::*;
#(
  parameter int N = 4,
  parameter int W = 8,
  parameter int S = W + $clog2(N)
) (
  input  logic [N*W-1:0]     operands,
  output logic [(N-1)*S-1:0] node_sums
);

  localparam int L = $clog2(N);

  logic [S-1:0] sum_a [N-1];

  always_comb begin
    for (int k = 0; k < N - 1; k++) sum_a[k] = '0;
    for (int l = 0; l < L; l++) begin
      for (int i = 0; i < (N >> (l + 1)); i++) begin
        if (l == 0)
          sum_a[node_idx(N, 0, i)] = S'(operands[(2*i)*W +: W]) + S'(operands[(2*i+1)*W +: W]);
        else
          sum_a[node_idx(N, l, i)] = sum_a[node_idx(N, l-1, 2*i)] + sum_a[node_idx(N, l-1, 2*i+1)];
      end
    end
  end

  always_comb begin
    node_sums = '0;
    for (int k = 0; k < N - 1; k++) node_sums[k*S +: S] = sum_a[k];
  end

endmodule

// File: rtl/redtree_sched.sv
// Captures one beat of operand/vec-id pairs and drains its maximal same-id
// subtree sums one per cycle, lowest covered leaf first.
module redtree_sched
  import redtree_pkg::*;
#(
  parameter int N = 4,
  parameter int W = 8,
  parameter int V = 3,
  parameter int S = W + $clog2(N)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N*W-1:0] in_operands,
  input  logic [N*V-1:0] in_vec_ids,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [S-1:0]   out_sum,
  output logic [V-1:0]   out_vec_id,
  output logic           out_last,
  output logic           busy
);

  localparam int NC = num_cand(N);
  localparam int L  = $clog2(N);
  localparam int IW = $clog2(N);

  state_t         state_q, state_d;
  logic [N-1:0]   pending_q, pending_d;
  logic [N*W-1:0] ops_q, ops_d;
  logic [N*V-1:0] ids_q, ids_d;

  logic [(N-1)*S-1:0] node_sums;
  logic [NC-1:0]      res_in, res_cap;
  logic [N-1:0]       start_in, pend_rest;
  logic [IW-1:0]      sel;
  logic [S-1:0]       sum_sel;
  logic [V-1:0]       id_sel;
  logic               fire_out;

  // Candidates 0..N-1 are leaves, N+node_idx(...) are tree nodes.
  function automatic logic [NC-1:0] result_mask(input logic [N*V-1:0] ids);
    logic [NC-1:0] uni;
    logic [NC-1:0] res;
    int c, a;
    uni = '0;
    res = '0;
    for (int k = 0; k < N; k++) uni[k] = 1'b1;
    for (int l = 0; l < L; l++) begin
      for (int i = 0; i < (N >> (l + 1)); i++) begin
        c = N + node_idx(N, l, i);
        a = (l == 0) ? 2 * i : N + node_idx(N, l - 1, 2 * i);
        uni[c] = uni[a] && uni[a+1] &&
                 (ids[((2*i) << l)*V +: V] == ids[((2*i+1) << l)*V +: V]);
      end
    end
    for (int k = 0; k < N; k++) res[k] = !uni[N + node_idx(N, 0, k / 2)];
    for (int l = 0; l < L; l++) begin
      for (int i = 0; i < (N >> (l + 1)); i++) begin
        c = N + node_idx(N, l, i);
        if (l == L - 1) res[c] = uni[c];
        else            res[c] = uni[c] && !uni[N + node_idx(N, l + 1, i / 2)];
      end
    end
    return res;
  endfunction

  // Results partition the leaves, so each is uniquely keyed by its lowest leaf.
  function automatic logic [N-1:0] start_mask(input logic [NC-1:0] res);
    logic [N-1:0] st;
    st = '0;
    for (int k = 0; k < N; k++) if (res[k]) st[k] = 1'b1;
    for (int l = 0; l < L; l++)
      for (int i = 0; i < (N >> (l + 1)); i++)
        if (res[N + node_idx(N, l, i)]) st[i << (l + 1)] = 1'b1;
    return st;
  endfunction

  fan_sum_tree #(.N(N), .W(W), .S(S)) u_tree (
    .operands  (ops_q),
    .node_sums (node_sums)
  );

  always_comb begin
    res_in   = result_mask(in_vec_ids);
    res_cap  = result_mask(ids_q);
    start_in = start_mask(res_in);

    sel = '0;
    for (int k = N - 1; k >= 0; k--) if (pending_q[k]) sel = IW'(k);

    sum_sel = '0;
    id_sel  = '0;
    for (int k = 0; k < N; k++) begin
      if (res_cap[k] && sel == IW'(k)) sum_sel = S'(ops_q[k*W +: W]);
      if (sel == IW'(k)) id_sel = ids_q[k*V +: V];
    end
    for (int l = 0; l < L; l++)
      for (int i = 0; i < (N >> (l + 1)); i++)
        if (res_cap[N + node_idx(N, l, i)] && sel == IW'(i << (l + 1)))
          sum_sel = node_sums[node_idx(N, l, i)*S +: S];

    pend_rest  = pending_q & (pending_q - N'(1));
    out_valid  = |pending_q;
    out_last   = out_valid && (pend_rest == '0);
    out_sum    = out_valid ? sum_sel : '0;
    out_vec_id = out_valid ? id_sel : '0;
    busy       = (state_q != IDLE);
    fire_out   = out_valid && out_ready;
    in_ready   = !rst && ((state_q == IDLE) || (fire_out && out_last));
  end

  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    ops_d     = ops_q;
    ids_d     = ids_q;
    if (state_q == DRAIN && fire_out) begin
      pending_d = pend_rest;
      if (out_last && !in_valid) state_d = IDLE;
    end
    if (in_valid && in_ready) begin
      ops_d     = in_operands;
      ids_d     = in_vec_ids;
      pending_d = start_in;
      state_d   = DRAIN;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      pending_q <= '0;
      ops_q     <= '0;
      ids_q     <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      ops_q     <= ops_d;
      ids_q     <= ids_d;
    end
  end

endmodule

// File: tb/tb_redtree_sched.sv
// Bench for redtree_sched: partition model with result queue, directed plan
// cases with literal expectations, then randomized traffic with resets.
module tb_redtree_sched;

  localparam int N = 4;
  localparam int W = 8;
  localparam int V = 3;
  localparam int S = 10;

  typedef struct packed {
    logic [S-1:0] sum;
    logic [V-1:0] id;
  } res_t;

  logic           clk = 1'b0;
  logic           rst;
  logic           in_valid;
  logic           in_ready;
  logic [N*W-1:0] in_operands;
  logic [N*V-1:0] in_vec_ids;
  logic           out_valid;
  logic           out_ready;
  logic [S-1:0]   out_sum;
  logic [V-1:0]   out_vec_id;
  logic           out_last;
  logic           busy;

  int errors = 0;
  int checks = 0;
  res_t q[$];
  res_t mres[$];

  redtree_sched #(.N(N), .W(W), .V(V), .S(S)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_operands (in_operands),
    .in_vec_ids  (in_vec_ids),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_sum     (out_sum),
    .out_vec_id  (out_vec_id),
    .out_last    (out_last),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Greedy split: at each position take the largest aligned uniform block.
  function automatic void model_beat(input logic [N*V-1:0] ids, input logic [N*W-1:0] ops);
    int idv[N];
    int opv[N];
    int lo, len, s;
    bit uni;
    res_t r;
    mres.delete();
    for (int j = 0; j < N; j++) begin
      idv[j] = int'(ids[j*V +: V]);
      opv[j] = int'(ops[j*W +: W]);
    end
    lo = 0;
    while (lo < N) begin
      for (len = N; len >= 1; len = len / 2) begin
        if ((lo % len) == 0 && lo + len <= N) begin
          uni = 1'b1;
          s = 0;
          for (int j = lo; j < lo + len; j++) begin
            if (idv[j] != idv[lo]) uni = 1'b0;
            s += opv[j];
          end
          if (uni) begin
            r.sum = S'(s);
            r.id  = V'(idv[lo]);
            mres.push_back(r);
            lo += len;
            break;
          end
        end
      end
    end
  endfunction

  function automatic logic [N*V-1:0] pk_ids(input int a0, a1, a2, a3);
    return {V'(a3), V'(a2), V'(a1), V'(a0)};
  endfunction

  function automatic logic [N*W-1:0] pk_ops(input int a0, a1, a2, a3);
    return {W'(a3), W'(a2), W'(a1), W'(a0)};
  endfunction

  // Per-cycle compare against the model, then advance the model.
  always @(negedge clk) begin
    bit exp_ready;
    exp_ready = !rst && (q.size() == 0 || (out_ready && q.size() == 1));
    chk("in_ready", int'(in_ready), int'(exp_ready));
    if (!rst) begin
      chk("out_valid", int'(out_valid), int'(q.size() != 0));
      chk("busy", int'(busy), int'(q.size() != 0));
      if (q.size() != 0) begin
        chk("out_sum", int'(out_sum), int'(q[0].sum));
        chk("out_vec_id", int'(out_vec_id), int'(q[0].id));
        chk("out_last", int'(out_last), int'(q.size() == 1));
      end
    end
    if (rst) q.delete();
    else begin
      if (q.size() != 0 && out_ready) void'(q.pop_front());
      if (in_valid && exp_ready) begin
        model_beat(in_vec_ids, in_operands);
        foreach (mres[k]) q.push_back(mres[k]);
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic send_beat(input logic [N*V-1:0] ids, input logic [N*W-1:0] ops);
    bit got;
    in_vec_ids  = ids;
    in_operands = ops;
    in_valid    = 1'b1;
    got = 1'b0;
    for (int t = 0; t < 50 && !got; t++) begin
      @(negedge clk);
      if (in_ready) got = 1'b1;
      cyc();
    end
    in_valid = 1'b0;
    if (!got) chk("send_timeout", 0, 1);
  endtask

  task automatic expect_out(input int s, input int id, input int last);
    @(negedge clk);
    chk("lit_valid", int'(out_valid), 1);
    chk("lit_sum", int'(out_sum), s);
    chk("lit_id", int'(out_vec_id), id);
    chk("lit_last", int'(out_last), last);
    cyc();
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    in_operands = '0;
    in_vec_ids = '0;

    model_beat(pk_ids(0, 1, 1, 1), pk_ops(1, 2, 3, 4));
    chk("model_cnt_0111", mres.size(), 3);
    chk("model_sum2_0111", int'(mres[2].sum), 7);
    chk("model_id1_0111", int'(mres[1].id), 1);
    model_beat(pk_ids(1, 1, 3, 3), pk_ops(255, 255, 255, 255));
    chk("model_cnt_1133", mres.size(), 2);
    chk("model_sum1_1133", int'(mres[1].sum), 510);
    model_beat(pk_ids(0, 1, 2, 3), pk_ops(5, 6, 7, 8));
    chk("model_cnt_0123", mres.size(), 4);

    cyc(); cyc();
    @(negedge clk);
    chk("rst_in_ready", int'(in_ready), 0);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_out_sum", int'(out_sum), 0);
    chk("rst_out_vec_id", int'(out_vec_id), 0);
    chk("rst_out_last", int'(out_last), 0);
    cyc();
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", int'(in_ready), 1);
    cyc();

    send_beat(pk_ids(2, 2, 2, 2), pk_ops(1, 2, 3, 4));
    expect_out(10, 2, 1);
    send_beat(pk_ids(0, 1, 2, 3), pk_ops(5, 6, 7, 8));
    expect_out(5, 0, 0);
    expect_out(6, 1, 0);
    expect_out(7, 2, 0);
    expect_out(8, 3, 1);
    send_beat(pk_ids(1, 1, 3, 3), pk_ops(255, 255, 255, 255));
    expect_out(510, 1, 0);
    expect_out(510, 3, 1);
    send_beat(pk_ids(7, 7, 7, 7), pk_ops(255, 255, 255, 255));
    expect_out(1020, 7, 1);
    send_beat(pk_ids(0, 1, 1, 1), pk_ops(1, 2, 3, 4));
    expect_out(1, 0, 0);
    expect_out(2, 1, 0);
    expect_out(7, 1, 1);

    // Backpressure at the 2nd result, then a back-to-back beat.
    send_beat(pk_ids(0, 1, 2, 3), pk_ops(5, 6, 7, 8));
    expect_out(5, 0, 0);
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("bp_sum", int'(out_sum), 6);
      chk("bp_id", int'(out_vec_id), 1);
      chk("bp_last", int'(out_last), 0);
      chk("bp_in_ready", int'(in_ready), 0);
      cyc();
    end
    out_ready = 1'b1;
    expect_out(6, 1, 0);
    expect_out(7, 2, 0);
    in_vec_ids  = pk_ids(2, 2, 2, 2);
    in_operands = pk_ops(1, 2, 3, 4);
    in_valid    = 1'b1;
    @(negedge clk);
    chk("b2b_in_ready", int'(in_ready), 1);
    chk("b2b_sum", int'(out_sum), 8);
    chk("b2b_last", int'(out_last), 1);
    cyc();
    in_valid = 1'b0;
    expect_out(10, 2, 1);
    @(negedge clk);
    chk("b2b_idle_valid", int'(out_valid), 0);
    cyc();

    // Reset in the middle of a drain.
    send_beat(pk_ids(0, 1, 2, 3), pk_ops(5, 6, 7, 8));
    expect_out(5, 0, 0);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_in_ready", int'(in_ready), 0);
    cyc();
    rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_valid", int'(out_valid), 0);
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_in_ready", int'(in_ready), 1);
    cyc();
    @(negedge clk);
    chk("mid_rst_stale", int'(out_valid), 0);
    cyc();

    for (int c = 0; c < 600; c++) begin
      rst       = ($urandom_range(0, 49) == 0);
      in_valid  = ($urandom_range(0, 2) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 1) == 0)
        in_vec_ids = pk_ids($urandom_range(0, 1), $urandom_range(0, 1),
                            $urandom_range(0, 1), $urandom_range(0, 1));
      else
        in_vec_ids = N*V'($urandom);
      in_operands = $urandom;
      cyc();
    end
    rst = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 10; c++) cyc();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
